// File: rtl/sensor_hub_pkg.sv
// Shared definitions for the sensor hub host command path: command bytes,
// receiver state encoding and the oversampling divider helper.
package sensor_hub_pkg;

    // Command bytes accepted from the host (upper and lower case)
    localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_READ_LC = 8'h72;  // 'r'
    localparam logic [7:0] CMD_AUTO    = 8'h41;  // 'A'
    localparam logic [7:0] CMD_AUTO_LC = 8'h61;  // 'a'
    localparam logic [7:0] CMD_STOP    = 8'h53;  // 'S'
    localparam logic [7:0] CMD_STOP_LC = 8'h73;  // 's'

    // Bytes a terminal typically sends between commands; dropped silently
    localparam logic [7:0] IGN_CR    = 8'h0D;
    localparam logic [7:0] IGN_LF    = 8'h0A;
    localparam logic [7:0] IGN_SPACE = 8'h20;

    // Serial receiver states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Meaning of a correctly framed byte
    typedef enum logic [2:0] {
        KIND_IGNORE,
        KIND_READ,
        KIND_AUTO,
        KIND_STOP,
        KIND_BAD
    } cmd_kind_t;

    // Clock cycles per oversample tick at 16x oversampling
    function automatic int os_div(input int clk_freq, input int baud);
        return clk_freq / (baud * 16);
    endfunction

    // Map a received byte onto the action it requests
    function automatic cmd_kind_t classify(input logic [7:0] b);
        cmd_kind_t kind;
        kind = KIND_BAD;
        case (b)
            CMD_READ, CMD_READ_LC:        kind = KIND_READ;
            CMD_AUTO, CMD_AUTO_LC:        kind = KIND_AUTO;
            CMD_STOP, CMD_STOP_LC:        kind = KIND_STOP;
            IGN_CR, IGN_LF, IGN_SPACE:    kind = KIND_IGNORE;
            default:                      kind = KIND_BAD;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/uart_cmd_trigger_if.sv
// Host command link: the serial line in, plus the trigger/status outputs
// presented to the sensor hub. The master side drives rx, the slave is the
// command front end.
interface uart_cmd_trigger_if;
    logic       rx;
    logic       trigger;
    logic       auto_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_err;

    modport master (
        output rx,
        input  trigger,
        input  auto_en,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  cmd_err
    );

    modport slave (
        input  rx,
        output trigger,
        output auto_en,
        output rx_data,
        output rx_valid,
        output frame_err,
        output cmd_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling. Synchronises the raw line,
// detects the start edge, samples each bit at its centre and reports either a
// good byte (valid) or a low stop bit (frame_err) as single-cycle pulses.
module uart_rx
    import sensor_hub_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int              OS_DIV    = os_div(CLK_FREQ, BAUD);
    localparam int              OS_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_DIV - 1);
    localparam logic [3:0]      MID_START = 4'd7;   // half a bit after the edge
    localparam logic [3:0]      LAST_TICK = 4'd15;  // one full bit later

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic            start_edge;
    logic [OS_W-1:0] os_cnt;
    logic            os_tick;
    rx_state_t       state;
    logic [3:0]      tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    // Two-flop synchroniser plus a previous-sample flop for edge detection
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make each flop take the pre-edge
        // value of its neighbour; blocking ones would collapse the chain.
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign os_tick    = (os_cnt == OS_LAST);

    // Oversample divider, re-phased on the start edge so ticks land mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt <= '0;
        end else if ((state == IDLE) && start_edge) begin
            os_cnt <= '0;
        end else if (os_tick) begin
            os_cnt <= '0;
        end else begin
            os_cnt <= os_cnt + 1'b1;
        end
    end

    // Frame FSM: start check, eight LSB-first data bits, stop bit check
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (os_tick) begin
                        if (tick_cnt == MID_START) begin
                            tick_cnt <= '0;
                            if (!rx_sync) begin
                                bit_idx <= '0;
                                state   <= DATA;
                            end else begin
                                // Line already back high: a glitch, not a start bit
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (os_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shift    <= {rx_sync, shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (os_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            if (rx_sync) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            // A held-low line leaves rx_prev low, so no re-arm
                            state <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_trigger.sv
// Host command front end for the sensor hub. Decodes single-character
// commands from the serial receiver into trigger pulses and runs the
// free-running auto-sample period counter.
module uart_cmd_trigger
    import sensor_hub_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD          = 9600,
    parameter int PERIOD_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_trigger_if.slave   bus
);

    localparam int               PER_W    = $clog2(PERIOD_CYCLES);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);

    logic [7:0]       rx_byte;
    logic             rx_ok;
    logic             rx_bad_frame;
    cmd_kind_t        kind;
    logic             wrap;
    logic             trig_req;
    logic             err_req;
    logic             trig_q;
    logic             auto_q;
    logic             cerr_q;
    logic [PER_W-1:0] per_cnt;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (bus.rx),
        .data      (rx_byte),
        .valid     (rx_ok),
        .frame_err (rx_bad_frame)
    );

    assign kind = classify(rx_byte);
    assign wrap = auto_q && (per_cnt == PER_LAST);

    // Merge decoded commands with the period wrap into one trigger request
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        trig_req = wrap;
        err_req  = 1'b0;
        if (rx_ok) begin
            case (kind)
                KIND_READ, KIND_AUTO: trig_req = 1'b1;
                KIND_STOP:            trig_req = 1'b0;  // stop cancels this wrap
                KIND_BAD:             err_req  = 1'b1;
                default:              ;
            endcase
        end
    end

    // Registered decoder outputs and the auto-sample period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q  <= 1'b0;
            auto_q  <= 1'b0;
            cerr_q  <= 1'b0;
            per_cnt <= '0;
        end else begin
            // Never two trigger cycles in a row; the hub is busy anyway
            trig_q <= trig_req & ~trig_q;
            // An unknown byte landing on an auto wrap yields to the trigger
            cerr_q <= err_req & ~trig_req;
            if (rx_ok && ((kind == KIND_AUTO) || (kind == KIND_STOP))) begin
                auto_q  <= (kind == KIND_AUTO);
                per_cnt <= '0;
            end else if (auto_q) begin
                per_cnt <= wrap ? '0 : per_cnt + 1'b1;
            end
        end
    end

    assign bus.trigger   = trig_q;
    assign bus.auto_en   = auto_q;
    assign bus.rx_data   = rx_byte;
    assign bus.rx_valid  = rx_ok;
    assign bus.frame_err = rx_bad_frame;
    assign bus.cmd_err   = cerr_q;

endmodule

// File: doc/uart_cmd_trigger.md
Name: uart_cmd_trigger

Overview:
- Host-side command front end that sits directly upstream of the sensor hub's `trigger` input.
- Receives 8N1 serial bytes from the host on `rx` and decodes single-character commands.
- Produces a 1-cycle `trigger` pulse per requested read, plus a free-running auto-sample mode at a fixed period.
- It is the receive-direction counterpart of the hub's serial TX path and shares its baud configuration.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; OS_DIV = CLK_FREQ/(BAUD*16) is an integer ≥ 1 (16x oversampling).
- PERIOD_CYCLES, 100_000_000, clk cycles between auto-mode triggers (≥ 2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- trigger  out  1  1-cycle pulse requesting one sensor read.
- auto_en  out  1  level, high while auto-sample mode is active.
- rx_data  out  8  last correctly framed byte; held until the next one.
- rx_valid  out  1  1-cycle pulse, rx_data updated this cycle.
- frame_err  out  1  1-cycle pulse, stop bit sampled low.
- cmd_err  out  1  1-cycle pulse, valid byte that is not a known command.

Behaviour:
- Reset values:
  - trigger, auto_en, rx_valid, frame_err, cmd_err = 0; rx_data = 0x00.
  - Synchroniser flops = 1; RX FSM = IDLE; all counters = 0.
- Reset is honoured on any cycle, including mid-frame: the partial byte is discarded and no pulse is emitted.
- Input conditioning: 2-flop synchroniser on rx, followed by a previous-sample register used for falling-edge detection.
- Oversample tick: a counter 0..OS_DIV-1 pulses `os_tick` on wrap. It restarts at 0 on start-edge detection so bit sampling is phase-aligned.
- RX FSM states:
  - IDLE: on a synchronised 1→0 edge, clear the sample counter and go to START.
  - START: at os_tick count 7 (mid-bit), if rx=0 go to DATA with bit index 0; else treat as a glitch and return to IDLE with no pulse.
  - DATA: every 16 os_ticks, sample one bit, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: 16 os_ticks later (mid stop bit):
    - rx=1: rx_data ← shift and rx_valid pulses.
    - rx=0: frame_err pulses and rx_data is unchanged.
    - Either way, return to IDLE. A new frame needs a fresh 1→0 edge, so a held-low line (break) does not retrigger.
- Command decode acts on rx_valid; its outputs are registered and appear 1 cycle after rx_valid:
  - 0x52 'R' / 0x72 'r': one trigger pulse.
  - 0x41 'A' / 0x61 'a': auto_en←1, period counter←0, one immediate trigger pulse. If auto_en is already 1, restart the period the same way.
  - 0x53 'S' / 0x73 's': auto_en←0, period counter←0, no trigger.
  - 0x0D, 0x0A, 0x20: ignored silently.
  - Any other byte: cmd_err pulse.
- Auto mode: while auto_en=1 the period counter counts 0..PERIOD_CYCLES-1. trigger pulses on the cycle the counter wraps to 0, so consecutive auto triggers are exactly PERIOD_CYCLES apart.
- Simultaneous events: a decoded 'R' and a period wrap on the same cycle give a single trigger pulse, and the period counter is not reset. An 'S' on a wrap cycle suppresses that wrap's trigger.
- trigger is never high for 2 consecutive cycles; the downstream hub ignores triggers while busy.
- rx_valid and frame_err are mutually exclusive. cmd_err and trigger are mutually exclusive.

Decomposition:
- Shared package `sensor_hub_pkg`:
  - Command byte constants: CMD_READ, CMD_AUTO, CMD_STOP, plus the lowercase variants.
  - Ignored-byte constants.
  - RX FSM state encoding: IDLE, START, DATA, STOP.
  - OS_DIV computation function.
- Sub-module `uart_rx` (params CLK_FREQ, BAUD; ports clk, rst, rx → data, valid, frame_err): contains the synchroniser, oversampler and RX FSM.
- uart_cmd_trigger instantiates uart_rx and adds the decoder and period counter.

Test Plan (bench params: CLK_FREQ=1_600_000, BAUD=100_000 so OS_DIV=1 and 16 clk/bit; PERIOD_CYCLES=1000):
- Reset, then send 'R' (0x52) → rx_valid with rx_data=0x52 once; trigger pulses exactly 1 cycle later; auto_en stays 0; no error pulses.
- Send 'A' → immediate trigger, auto_en=1; triggers then repeat every 1000 cycles for 3 periods. Send 'S' → auto_en=0, no further triggers over 3000 cycles.
- Send 0x52 with the stop bit driven low → frame_err pulse, no rx_valid, no trigger, rx_data keeps its prior value. Send 'x' (0x78) → cmd_err pulse, no trigger. Send 0x0D → no pulses at all.
- 6-cycle low glitch on idle rx → no rx_valid and no frame_err. The next valid 'r' frame still decodes and produces a trigger.
- Assert rst during bit 4 of a frame → all outputs return to reset values, no rx_valid. The next full 'R' frame decodes correctly.
- While auto_en=1, time an 'R' decode to the period-wrap cycle → exactly one trigger pulse; the next auto trigger arrives 1000 cycles later.
